// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU.
//   op_e    : operation encoding on the op port
//   state_e : control FSM states
//   FLAG_*  : bit positions inside the 4-bit flags word {N, Z, C, V}
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative radix-2 shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load operands, clear accumulator, counter = WIDTH
//   i_a, i_b   : multiplicand, multiplier (sampled on i_start only)
//   o_done     : high during the final step; o_product is then the full product
//   o_product  : accumulator value after the current step (2*WIDTH bits)
module seq_mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_step;

  always_comb begin
    w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
    o_done     = (r_cnt == CntW'(1));
    o_product  = w_acc_step;
  end

  // No early exit: the counter always runs the full WIDTH steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_cnt    <= CntW'(WIDTH);
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CntW'(1);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_step;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: add, reverse-subtract, iterative multiply, rotate-right.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready only in IDLE)
//   in1, in2, op        : operands and opcode, sampled at accept
//   out_valid/out_ready : result handshake; result and flags held until taken
//   result, flags       : result and {N, Z, C, V}
//   result_hi           : high half of the product (only with SEQ_ALU_MUL_HI_EN defined)
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
`ifdef SEQ_ALU_MUL_HI_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_result, w_result_d;
  logic [3:0]         r_flags, w_flags_d;
`ifdef SEQ_ALU_MUL_HI_EN
  logic [WIDTH-1:0]   r_result_hi, w_result_hi_d;
`endif

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH:0]     w_add_full;
  logic [WIDTH-1:0]   w_sub;
  logic [SHAMT_W-1:0] w_ror_amt;
  logic [WIDTH-1:0]   w_ror;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_mul_start = w_accept && (op_e'(op) == OP_MUL);

  seq_mul_unit #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (in1),
    .i_b       (in2),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Single-cycle datapath for add / sub / ror.
  always_comb begin
    w_add_full = {1'b0, in1} + {1'b0, in2};
    w_sub      = in2 - in1;
    w_ror_amt  = in1[SHAMT_W-1:0];
    // A shift by WIDTH yields zero, so amount 0 collapses to in2.
    w_ror      = (in2 >> w_ror_amt) | (in2 << (WIDTH - 32'(w_ror_amt)));

    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    unique case (op_e'(op))
      OP_ADD: begin
        w_alu_res = w_add_full[WIDTH-1:0];
        w_alu_c   = w_add_full[WIDTH];
        w_alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_add_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub;
        w_alu_c   = (in2 >= in1);
        w_alu_v   = (in2[WIDTH-1] != in1[WIDTH-1]) && (w_sub[WIDTH-1] != in2[WIDTH-1]);
      end
      OP_ROR: begin
        w_alu_res = w_ror;
        w_alu_c   = w_ror[WIDTH-1];
      end
      OP_MUL: begin
        // Handled by the multiplier unit.
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_result_d    = r_result;
    w_flags_d     = r_flags;
`ifdef SEQ_ALU_MUL_HI_EN
    w_result_hi_d = r_result_hi;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (op_e'(op) == OP_MUL) begin
            w_state_d = MUL;
          end else begin
            w_state_d     = DONE;
            w_result_d    = w_alu_res;
            w_flags_d     = pack_flags(w_alu_res[WIDTH-1], w_alu_res == '0, w_alu_c, w_alu_v);
`ifdef SEQ_ALU_MUL_HI_EN
            w_result_hi_d = '0;
`endif
          end
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_d     = DONE;
          w_result_d    = w_product[WIDTH-1:0];
          w_flags_d     = pack_flags(w_product[WIDTH-1], w_product[WIDTH-1:0] == '0,
                                     w_product[2*WIDTH-1:WIDTH] != '0, 1'b0);
`ifdef SEQ_ALU_MUL_HI_EN
          w_result_hi_d = w_product[2*WIDTH-1:WIDTH];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_flags     <= '0;
`ifdef SEQ_ALU_MUL_HI_EN
      r_result_hi <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_result    <= w_result_d;
      r_flags     <= w_flags_d;
`ifdef SEQ_ALU_MUL_HI_EN
      r_result_hi <= w_result_hi_d;
`endif
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;
`ifdef SEQ_ALU_MUL_HI_EN
  assign result_hi = r_result_hi;
`endif

endmodule
